// File: rtl/delay_sweep_sequencer.sv
// rtl/delay_sweep_sequencer.sv - 2-D coarse/fine trigger-delay sweep scheduler
module delay_sweep_sequencer #(
  parameter int LOCK_SETTLE  = 16,
  parameter int LOCK_TIMEOUT = 1_000_000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      coarse_start,
  input  logic [31:0]      coarse_step,
  input  logic [CNT_W-1:0] coarse_count,
  input  logic [15:0]      fine_start,
  input  logic [15:0]      fine_step,
  input  logic [CNT_W-1:0] fine_count,
  input  logic [CNT_W-1:0] repeats,
  input  logic             trigger_pulse,
  input  logic             mmcm_locked,
  output logic [31:0]      coarse_delay,
  output logic             coarse_update,
  output logic [15:0]      fine_delay_ps,
  output logic             fine_update,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic             lock_error,
  output logic [CNT_W-1:0] coarse_idx,
  output logic [CNT_W-1:0] fine_idx
);

  // Lock counter is wide enough to reach the timeout value itself.
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0]    SETTLE_C       = TW'(LOCK_SETTLE);
  localparam logic [TW-1:0]    TIMEOUT_LAST_C = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    LCNT_ONE_C     = TW'(1);
  localparam logic [CNT_W-1:0] ONE_C          = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LOCK,
    S_ARMED,
    S_ADVANCE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      coarse_delay_q, coarse_delay_d;
  logic [15:0]      fine_delay_q, fine_delay_d;
  logic [CNT_W-1:0] coarse_idx_q, coarse_idx_d;
  logic [CNT_W-1:0] fine_idx_q, fine_idx_d;
  logic [31:0]      coarse_step_q, coarse_step_d;
  logic [15:0]      fine_start_q, fine_start_d;
  logic [15:0]      fine_step_q, fine_step_d;
  logic [CNT_W-1:0] coarse_count_q, coarse_count_d;
  logic [CNT_W-1:0] fine_count_q, fine_count_d;
  logic [CNT_W-1:0] repeats_q, repeats_d;
  logic [TW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic             update_q, update_d;
  logic             done_q, done_d;
  logic             lock_err_q, lock_err_d;

  logic [CNT_W-1:0] trig_next;
  assign trig_next = trig_cnt_q + ONE_C;

  // State and datapath registers; rst returns everything to zero at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      coarse_delay_q <= '0;
      fine_delay_q   <= '0;
      coarse_idx_q   <= '0;
      fine_idx_q     <= '0;
      coarse_step_q  <= '0;
      fine_start_q   <= '0;
      fine_step_q    <= '0;
      coarse_count_q <= '0;
      fine_count_q   <= '0;
      repeats_q      <= '0;
      lock_cnt_q     <= '0;
      trig_cnt_q     <= '0;
      update_q       <= 1'b0;
      done_q         <= 1'b0;
      lock_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      coarse_delay_q <= coarse_delay_d;
      fine_delay_q   <= fine_delay_d;
      coarse_idx_q   <= coarse_idx_d;
      fine_idx_q     <= fine_idx_d;
      coarse_step_q  <= coarse_step_d;
      fine_start_q   <= fine_start_d;
      fine_step_q    <= fine_step_d;
      coarse_count_q <= coarse_count_d;
      fine_count_q   <= fine_count_d;
      repeats_q      <= repeats_d;
      lock_cnt_q     <= lock_cnt_d;
      trig_cnt_q     <= trig_cnt_d;
      update_q       <= update_d;
      done_q         <= done_d;
      lock_err_q     <= lock_err_d;
    end
  end

  // Next-state logic: abort has priority everywhere, including over a same-cycle start.
  always_comb begin
    state_d        = state_q;
    coarse_delay_d = coarse_delay_q;
    fine_delay_d   = fine_delay_q;
    coarse_idx_d   = coarse_idx_q;
    fine_idx_d     = fine_idx_q;
    coarse_step_d  = coarse_step_q;
    fine_start_d   = fine_start_q;
    fine_step_d    = fine_step_q;
    coarse_count_d = coarse_count_q;
    fine_count_d   = fine_count_q;
    repeats_d      = repeats_q;
    lock_cnt_d     = lock_cnt_q;
    trig_cnt_d     = trig_cnt_q;
    update_d       = 1'b0;
    done_d         = 1'b0;
    lock_err_d     = lock_err_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start && !abort) begin
          coarse_delay_d = coarse_start;
          fine_delay_d   = fine_start;
          coarse_step_d  = coarse_step;
          fine_start_d   = fine_start;
          fine_step_d    = fine_step;
          coarse_count_d = (coarse_count == '0) ? ONE_C : coarse_count;
          fine_count_d   = (fine_count == '0) ? ONE_C : fine_count;
          repeats_d      = (repeats == '0) ? ONE_C : repeats;
          coarse_idx_d   = '0;
          fine_idx_d     = '0;
          lock_err_d     = 1'b0;
          state_d        = S_LOAD;
        end
      end

      S_LOAD: begin
        // The strobe is registered, so it still fires if abort lands here.
        update_d   = 1'b1;
        lock_cnt_d = '0;
        trig_cnt_d = '0;
        state_d    = abort ? S_IDLE : S_WAIT_LOCK;
      end

      S_WAIT_LOCK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ((lock_cnt_q >= SETTLE_C) && mmcm_locked) begin
          state_d = S_ARMED;
        end else if (lock_cnt_q >= TIMEOUT_LAST_C) begin
          lock_err_d = 1'b1;
          state_d    = S_ERROR;
        end else begin
          lock_cnt_d = lock_cnt_q + LCNT_ONE_C;
        end
      end

      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!mmcm_locked) begin
          // Re-settle after a lock drop, but keep the triggers already counted.
          lock_cnt_d = '0;
          state_d    = S_WAIT_LOCK;
        end else if (trigger_pulse) begin
          trig_cnt_d = trig_next;
          if (trig_next == repeats_q) begin
            state_d = S_ADVANCE;
          end
        end
      end

      S_ADVANCE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fine_idx_q < (fine_count_q - ONE_C)) begin
          fine_idx_d   = fine_idx_q + ONE_C;
          fine_delay_d = fine_delay_q + fine_step_q;
          state_d      = S_LOAD;
        end else if (coarse_idx_q < (coarse_count_q - ONE_C)) begin
          fine_idx_d     = '0;
          fine_delay_d   = fine_start_q;
          coarse_idx_d   = coarse_idx_q + ONE_C;
          coarse_delay_d = coarse_delay_q + coarse_step_q;
          state_d        = S_LOAD;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign coarse_delay  = coarse_delay_q;
  assign fine_delay_ps = fine_delay_q;
  assign coarse_update = update_q;
  assign fine_update   = update_q;
  assign coarse_idx    = coarse_idx_q;
  assign fine_idx      = fine_idx_q;
  assign done          = done_q;
  assign lock_error    = lock_err_q;
  assign armed         = (state_q == S_ARMED);
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_delay_sweep_sequencer.sv
// tb/tb_delay_sweep_sequencer.sv - self-checking bench for delay_sweep_sequencer
module tb_delay_sweep_sequencer;

  localparam int LOCK_SETTLE  = 16;
  localparam int LOCK_TIMEOUT = 300;
  localparam int CNT_W        = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [31:0]      coarse_start;
  logic [31:0]      coarse_step;
  logic [CNT_W-1:0] coarse_count;
  logic [15:0]      fine_start;
  logic [15:0]      fine_step;
  logic [CNT_W-1:0] fine_count;
  logic [CNT_W-1:0] repeats;
  logic             trigger_pulse;
  logic             mmcm_locked;
  logic [31:0]      coarse_delay;
  logic             coarse_update;
  logic [15:0]      fine_delay_ps;
  logic             fine_update;
  logic             armed;
  logic             busy;
  logic             done;
  logic             lock_error;
  logic [CNT_W-1:0] coarse_idx;
  logic [CNT_W-1:0] fine_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] obs_q[$];
  int          done_cnt   = 0;
  int          strobe_mis = 0;

  always #5 clk = ~clk;

  delay_sweep_sequencer #(
    .LOCK_SETTLE (LOCK_SETTLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .coarse_start (coarse_start),
    .coarse_step  (coarse_step),
    .coarse_count (coarse_count),
    .fine_start   (fine_start),
    .fine_step    (fine_step),
    .fine_count   (fine_count),
    .repeats      (repeats),
    .trigger_pulse(trigger_pulse),
    .mmcm_locked  (mmcm_locked),
    .coarse_delay (coarse_delay),
    .coarse_update(coarse_update),
    .fine_delay_ps(fine_delay_ps),
    .fine_update  (fine_update),
    .armed        (armed),
    .busy         (busy),
    .done         (done),
    .lock_error   (lock_error),
    .coarse_idx   (coarse_idx),
    .fine_idx     (fine_idx)
  );

  // Record every emitted grid point, done pulse and any split strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (coarse_update && fine_update) obs_q.push_back({coarse_delay, fine_delay_ps});
      if (coarse_update !== fine_update) strobe_mis++;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger_pulse = 1'b1;
    tick();
    trigger_pulse = 1'b0;
  endtask

  task automatic wait_armed(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (armed === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic set_cfg(input logic [31:0] cs, input logic [31:0] cst, input logic [15:0] cc,
                         input logic [15:0] fs, input logic [15:0] fst, input logic [15:0] fc,
                         input logic [15:0] rep);
    coarse_start = cs; coarse_step = cst; coarse_count = cc;
    fine_start = fs; fine_step = fst; fine_count = fc; repeats = rep;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full sweep against a model that enumerates the grid with multiplication.
  task automatic run_sweep(input string name, input logic [31:0] cs, input logic [31:0] cst,
                           input logic [15:0] cc, input logic [15:0] fs, input logic [15:0] fst,
                           input logic [15:0] fc, input logic [15:0] rep);
    logic [47:0] exp_q[$];
    int ecc, efc, erep, base, dbase, smbase, npts;
    bit ok;
    ecc  = (cc == 0) ? 1 : int'(cc);
    efc  = (fc == 0) ? 1 : int'(fc);
    erep = (rep == 0) ? 1 : int'(rep);
    for (int c = 0; c < ecc; c++) begin
      for (int f = 0; f < efc; f++) begin
        logic [31:0] cv;
        logic [15:0] fv;
        cv = cs + cst * 32'(c);
        fv = fs + fst * 16'(f);
        exp_q.push_back({cv, fv});
      end
    end
    npts   = ecc * efc;
    base   = obs_q.size();
    dbase  = done_cnt;
    smbase = strobe_mis;
    mmcm_locked = 1'b1;
    abort = 1'b0;
    set_cfg(cs, cst, cc, fs, fst, fc, rep);
    pulse_start();
    n_checks++;
    if (coarse_update !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_latency_early: update=%b required 0", name, coarse_update);
    end
    tick();
    n_checks++;
    if (coarse_update !== 1'b1 || fine_update !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start_latency: coarse_update=%b fine_update=%b required 1/1", name, coarse_update, fine_update);
    end
    for (int p = 0; p < npts; p++) begin
      wait_armed(200, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s armed_timeout: point %0d armed=%b required 1", name, p, armed);
        return;
      end
      for (int r = 0; r < erep; r++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        pulse_trigger();
      end
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_latency_early: done=%b required 0", name, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_latency: done=%b required 1", name, done);
    end
    tick(); tick();
    n_checks++;
    if (obs_q.size() - base != npts) begin
      n_fail++;
      $display("FAIL %s point_count: got %0d required %0d", name, obs_q.size() - base, npts);
    end else begin
      for (int p = 0; p < npts; p++) begin
        n_checks++;
        if (obs_q[base + p] !== exp_q[p]) begin
          n_fail++;
          $display("FAIL %s point%0d: got %h/%h required %h/%h", name, p,
                   obs_q[base + p][47:16], obs_q[base + p][15:0], exp_q[p][47:16], exp_q[p][15:0]);
        end
      end
    end
    n_checks++;
    if (done_cnt - dbase != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt - dbase);
    end
    n_checks++;
    if (coarse_idx !== 16'(ecc - 1) || fine_idx !== 16'(efc - 1)) begin
      n_fail++;
      $display("FAIL %s final_idx: got %0d,%0d required %0d,%0d", name, coarse_idx, fine_idx, ecc - 1, efc - 1);
    end
    n_checks++;
    if (busy !== 1'b0 || lock_error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_state: busy=%b lock_error=%b required 0/0", name, busy, lock_error);
    end
    n_checks++;
    if (strobe_mis != smbase) begin
      n_fail++;
      $display("FAIL %s strobe_pairing: %0d split strobes required 0", name, strobe_mis - smbase);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({coarse_delay, fine_delay_ps, coarse_idx, fine_idx} !== '0 ||
        {coarse_update, fine_update, armed, busy, done, lock_error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: cd=%h fd=%h ci=%0d fi=%0d strobes=%b%b armed=%b busy=%b done=%b err=%b required all 0",
               coarse_delay, fine_delay_ps, coarse_idx, fine_idx, coarse_update, fine_update, armed, busy, done, lock_error);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic_grid();
    run_sweep("basic_grid", 32'd100, 32'd10, 16'd3, 16'd0, 16'd500, 16'd2, 16'd2);
  endtask

  task automatic test_random_grids();
    for (int k = 0; k < 4; k++) begin
      run_sweep("random_grid", $urandom, $urandom, 16'($urandom_range(1, 3)), 16'($urandom),
                16'($urandom), 16'($urandom_range(1, 3)), 16'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_lock_timeout();
    int n;
    bit fell;
    mmcm_locked = 1'b0;
    set_cfg(32'd77, 32'd1, 16'd2, 16'd9, 16'd1, 16'd2, 16'd1);
    pulse_start();
    n = 1;
    fell = 1'b0;
    for (int i = 0; i < LOCK_TIMEOUT + 100; i++) begin
      if (busy === 1'b0) begin
        fell = 1'b1;
        break;
      end
      tick();
      n++;
    end
    n_checks++;
    if (!fell) begin
      n_fail++;
      $display("FAIL lock_timeout_wait: busy=%b required 0 within budget", busy);
    end
    n_checks++;
    if (n < LOCK_TIMEOUT || n > LOCK_TIMEOUT + 3) begin
      n_fail++;
      $display("FAIL lock_timeout_time: error after %0d cycles required about %0d", n, LOCK_TIMEOUT);
    end
    n_checks++;
    if (lock_error !== 1'b1 || busy !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_timeout_state: lock_error=%b busy=%b armed=%b required 1/0/0", lock_error, busy, armed);
    end
    n_checks++;
    if (coarse_delay !== 32'd77 || fine_delay_ps !== 16'd9) begin
      n_fail++;
      $display("FAIL lock_timeout_hold: cd=%0d fd=%0d required 77/9", coarse_delay, fine_delay_ps);
    end
    repeat (5) tick();
    n_checks++;
    if (lock_error !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_error_sticky: lock_error=%b required 1", lock_error);
    end
    run_sweep("after_error", 32'd200, 32'd3, 16'd2, 16'd40, 16'd6, 16'd2, 16'd1);
  endtask

  task automatic test_lock_drop();
    bit ok;
    int armed_hi, dbase;
    mmcm_locked = 1'b1;
    dbase = done_cnt;
    set_cfg(32'd5, 32'd1, 16'd1, 16'd7, 16'd3, 16'd2, 16'd3);
    pulse_start();
    wait_armed(100, ok);
    pulse_trigger();
    mmcm_locked = 1'b0;
    tick();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_drop_armed: armed=%b required 0", armed);
    end
    armed_hi = 0;
    for (int i = 0; i < 49; i++) begin
      if (i == 10 || i == 20) pulse_trigger(); else tick();
      if (armed !== 1'b0) armed_hi++;
    end
    n_checks++;
    if (armed_hi != 0 || fine_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL lock_drop_hold: armed cycles=%0d fine_idx=%0d required 0/0", armed_hi, fine_idx);
    end
    mmcm_locked = 1'b1;
    wait_armed(100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL lock_drop_relock: armed=%b required 1", armed);
    end
    pulse_trigger();
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_drop_early_advance: armed=%b required 1 after 2 of 3", armed);
    end
    pulse_trigger();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_drop_advance: armed=%b required 0 after 3 of 3", armed);
    end
    tick();
    n_checks++;
    if (fine_idx !== 16'd1 || fine_delay_ps !== 16'd10) begin
      n_fail++;
      $display("FAIL lock_drop_next_point: fine_idx=%0d fd=%0d required 1/10", fine_idx, fine_delay_ps);
    end
    wait_armed(100, ok);
    repeat (3) pulse_trigger();
    repeat (3) tick();
    n_checks++;
    if (done_cnt - dbase != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_drop_done: done pulses=%0d busy=%b required 1/0", done_cnt - dbase, busy);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int busy_hi, dbase, base;
    mmcm_locked = 1'b1;
    dbase = done_cnt;
    set_cfg(32'd100, 32'd10, 16'd3, 16'd0, 16'd500, 16'd2, 16'd2);
    pulse_start();
    for (int p = 0; p < 2; p++) begin
      wait_armed(100, ok);
      repeat (2) pulse_trigger();
    end
    wait_armed(100, ok);
    n_checks++;
    if (!ok || coarse_idx !== 16'd1 || fine_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_point: armed=%b idx=%0d,%0d required 1 at 1,0", armed, coarse_idx, fine_idx);
    end
    base = obs_q.size();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0) busy_hi++;
      tick();
    end
    n_checks++;
    if (busy_hi != 0) begin
      n_fail++;
      $display("FAIL abort_idle: busy high %0d cycles required 0", busy_hi);
    end
    n_checks++;
    if (done_cnt != dbase || obs_q.size() != base) begin
      n_fail++;
      $display("FAIL abort_quiet: done pulses=%0d new points=%0d required 0/0", done_cnt - dbase, obs_q.size() - base);
    end
    n_checks++;
    if (coarse_delay !== 32'd110 || fine_delay_ps !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_hold: cd=%0d fd=%0d required 110/0", coarse_delay, fine_delay_ps);
    end
    run_sweep("restart_after_abort", 32'd100, 32'd10, 16'd3, 16'd0, 16'd500, 16'd2, 16'd2);
  endtask

  task automatic test_zero_counts();
    bit ok;
    int dbase, base;
    mmcm_locked = 1'b1;
    dbase = done_cnt;
    base = obs_q.size();
    set_cfg(32'd1234, 32'd9, 16'd0, 16'd321, 16'd9, 16'd0, 16'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      pulse_trigger();
      tick();
    end
    wait_armed(100, ok);
    tick(); tick();
    n_checks++;
    if (!ok || armed !== 1'b1 || done_cnt != dbase) begin
      n_fail++;
      $display("FAIL zero_early_triggers: armed=%b done pulses=%0d required 1/0", armed, done_cnt - dbase);
    end
    pulse_trigger();
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b required 1", done);
    end
    tick();
    n_checks++;
    if (obs_q.size() - base != 1 || done_cnt - dbase != 1 || obs_q[base] !== {32'd1234, 16'd321}) begin
      n_fail++;
      $display("FAIL zero_single_point: points=%0d done pulses=%0d required 1/1 at 1234/321",
               obs_q.size() - base, done_cnt - dbase);
    end
  endtask

  task automatic test_fine_wrap();
    int base;
    base = obs_q.size();
    run_sweep("fine_wrap", 32'd50, 32'd1, 16'd1, 16'hFFF0, 16'h0020, 16'd2, 16'd1);
    n_checks++;
    if (obs_q.size() < base + 2 || obs_q[base + 1][15:0] !== 16'h0010) begin
      n_fail++;
      $display("FAIL fine_wrap_value: second fine value wrong, required 0010");
    end
  endtask

  task automatic test_reset_midsweep();
    bit ok;
    mmcm_locked = 1'b1;
    set_cfg(32'd900, 32'd1, 16'd2, 16'd800, 16'd1, 16'd2, 16'd2);
    pulse_start();
    wait_armed(100, ok);
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || armed !== 1'b0 || coarse_delay !== 32'd0 || fine_delay_ps !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_midsweep: busy=%b armed=%b cd=%0d fd=%0d required 0/0/0/0", busy, armed, coarse_delay, fine_delay_ps);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; trigger_pulse = 1'b0; mmcm_locked = 1'b1;
    set_cfg(32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    test_reset();
    test_basic_grid();
    test_random_grids();
    test_lock_timeout();
    test_lock_drop();
    test_abort();
    test_zero_counts();
    test_fine_wrap();
    test_reset_midsweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_sweep_sequencer.md
Name: delay_sweep_sequencer

Overview:
Autonomous scheduler that sweeps the coarse and fine trigger-delay settings across a 2-D grid without host intervention per point. It sits between the UART command FSM and the enhanced trigger-delay datapath. It drives that datapath's coarse_delay/coarse_update and fine_delay_ps/fine_update. Per grid point it waits for MMCM re-lock, then counts a programmed number of accepted triggers before advancing.

Parameters:
LOCK_SETTLE, 16, minimum cycles after a fine update before mmcm_locked is sampled (covers MMCM lock-drop latency)
LOCK_TIMEOUT, 1_000_000, maximum cycles in WAIT_LOCK before a lock error is declared
CNT_W, 16, width of the coarse_count, fine_count and repeats inputs and of the index outputs

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; latches the config inputs and begins the sweep
abort  in  1  one-cycle pulse; stops the sweep
coarse_start  in  32  first coarse delay, in cycles
coarse_step  in  32  coarse increment per outer step
coarse_count  in  CNT_W  number of coarse points (0 treated as 1)
fine_start  in  16  first fine delay, in ps
fine_step  in  16  fine increment per inner step
fine_count  in  CNT_W  number of fine points (0 treated as 1)
repeats  in  CNT_W  triggers per grid point (0 treated as 1)
trigger_pulse  in  1  one-cycle accepted-edge pulse from the edge detector
mmcm_locked  in  1  MMCM lock status from the datapath
coarse_delay  out  32  coarse delay presented to the datapath
coarse_update  out  1  one-cycle load strobe for coarse_delay
fine_delay_ps  out  16  fine delay presented to the datapath
fine_update  out  1  one-cycle load strobe for fine_delay_ps
armed  out  1  high while triggers are being counted for the current point
busy  out  1  high in every state except IDLE and ERROR
done  out  1  one-cycle pulse on sweep completion
lock_error  out  1  sticky; set on lock timeout, cleared by start or rst
coarse_idx  out  CNT_W  current coarse index
fine_idx  out  CNT_W  current fine index

Behaviour:
- Reset: state IDLE. All outputs 0, including coarse_delay, fine_delay_ps, the indices and all internal counters.
- start, in IDLE or ERROR: latch the config inputs; remap counts of 0 to 1; set indices to 0; coarse_delay <= coarse_start; fine_delay_ps <= fine_start; clear lock_error. Next state is LOAD. start is ignored while busy.
- LOAD (1 cycle): assert coarse_update and fine_update together; clear the settle/timeout counter and the trigger counter. Next state is WAIT_LOCK.
- WAIT_LOCK: count cycles. Once count >= LOCK_SETTLE and mmcm_locked=1, go to ARMED. If count reaches LOCK_TIMEOUT first, set lock_error and go to ERROR; coarse_delay and fine_delay_ps hold their values.
- ARMED: armed=1. Each trigger_pulse increments trig_cnt. On the pulse where trig_cnt+1 == repeats, go to ADVANCE. trigger_pulse is ignored in every other state.
- mmcm_locked deasserting in ARMED: go back to WAIT_LOCK, clear its counter, keep trig_cnt.
- ADVANCE (1 cycle), fine index is the inner loop:
  - fine_idx < fine_count-1: fine_idx++, fine_delay_ps += fine_step; next state LOAD.
  - else, coarse_idx < coarse_count-1: fine_idx <= 0, fine_delay_ps <= fine_start, coarse_idx++, coarse_delay += coarse_step; next state LOAD.
  - else: done=1 for 1 cycle; next state IDLE; indices and delays hold their final values.
- Arithmetic: delays are accumulated, never multiplied. Wrap modulo 2^32 (coarse) or 2^16 (fine); no saturation, no error.
- LOAD always strobes both update lines, even when only one value changed.
- ERROR: busy=0; wait for start or rst.
- abort in any busy state: next state IDLE; no done pulse; delays hold their values; any update strobe already in flight completes. abort and start in the same cycle: abort wins and start is dropped. abort in IDLE or ERROR: no effect.
- rst mid-sweep: immediate return to reset values.
- Latency: start to first coarse_update/fine_update is 2 cycles. The final qualifying trigger_pulse to done is 2 cycles.

Test Plan:
- coarse 100/step 10/count 3, fine 0/step 500/count 2, repeats 2, mmcm_locked held 1. Supply 12 trigger pulses -> coarse/fine sequence (100,0),(100,500),(110,0),(110,500),(120,0),(120,500); each pair emitted with both update strobes; a single done pulse after the 12th trigger.
- mmcm_locked held 0 for LOCK_TIMEOUT cycles after the first LOAD -> lock_error=1, busy=0, state ERROR. A following start clears lock_error and restarts at index (0,0).
- mmcm_locked drops for 50 cycles in ARMED after 1 of 3 triggers -> armed falls, no advance. After re-lock, exactly 2 more triggers advance the point.
- abort at point (1,0), with start pulsed in the same cycle -> IDLE, no done, coarse_delay stays 110. A later start alone restarts the sweep.
- All counts 0, repeats 0 -> a single grid point; done after 1 trigger. Triggers arriving during LOAD/WAIT_LOCK are not counted.
- fine_start 16'hFFF0, step 16'h0020, count 2 -> second fine value 16'h0010 (wrap, no error).
